// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one memory-controller port between instruction
// fetch (IC) and load/store (LS), one transaction at a time, with
// round-robin tie breaking, an IO back-pressure stall for LS writes and
// fetch cancellation on flush.
//
// state   | meaning
// IDLE    | no transaction; grant an eligible requester
// BUSY_IC | fetch issued to the controller, waiting for mc_ready
// BUSY_LS | load/store issued to the controller, waiting for mc_ready
// DONE    | completion pulse to the owner, requests ignored
module mem_arbiter (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_done,
    output logic [31:0] ic_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [2:0]  ls_len,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_value,
    output logic        ls_done,
    output logic [31:0] ls_data,
    input  logic        io_buffer_full,
    input  logic        flush,
    output logic        mc_waiting,
    output logic        mc_wr,
    output logic [2:0]  mc_len,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_value,
    input  logic        mc_ready,
    input  logic [31:0] mc_result
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IC = 2'd1,
        BUSY_LS = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        last_ls_q, last_ls_d;
    logic        owner_ls_q, owner_ls_d;
    logic        cancel_q, cancel_d;
    logic        first_q, first_d;
    logic        same_q, same_d;
    logic        prev_valid_q, prev_valid_d;
    logic [31:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] value_q, value_d;

    logic        ls_eligible;
    logic        ic_eligible;
    logic        grant_ls;
    logic        grant_ic;
    logic        req_wr;
    logic [2:0]  req_len;
    logic [31:0] req_addr;
    logic [31:0] req_value;

    // Eligibility, round-robin pick and the request fields of the winner.
    // An LS write to the IO window (addr[17:16]=11) waits while the IO FIFO
    // is full so that a fetch is not blocked behind it.
    always_comb begin
        ls_eligible = ls_req && !(ls_wr && (ls_addr[17:16] == 2'b11) && io_buffer_full);
        ic_eligible = ic_req && !flush;
        grant_ls    = ls_eligible && (!ic_eligible || !last_ls_q);
        grant_ic    = ic_eligible && !grant_ls;
        req_wr      = 1'b0;
        req_len     = 3'b010;
        req_addr    = ic_addr;
        req_value   = 32'h0;
        if (grant_ls) begin
            req_wr    = ls_wr;
            req_len   = ls_len;
            req_addr  = ls_addr;
            req_value = ls_value;
        end
    end

    // Next-state logic; everything holds while rdy_in is low.
    always_comb begin
        state_d      = state_q;
        last_ls_d    = last_ls_q;
        owner_ls_d   = owner_ls_q;
        cancel_d     = cancel_q;
        first_d      = first_q;
        same_d       = same_q;
        prev_valid_d = prev_valid_q;
        data_d       = data_q;
        wr_d         = wr_q;
        len_d        = len_q;
        addr_d       = addr_q;
        value_d      = value_q;
        if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (grant_ls || grant_ic) begin
                        state_d      = grant_ls ? BUSY_LS : BUSY_IC;
                        owner_ls_d   = grant_ls;
                        cancel_d     = 1'b0;
                        first_d      = 1'b1;
                        // Latches still hold the previous transaction here.
                        same_d       = prev_valid_q &&
                                       ({req_wr, req_len, req_addr, req_value} ==
                                        {wr_q, len_q, addr_q, value_q});
                        prev_valid_d = 1'b1;
                        wr_d         = req_wr;
                        len_d        = req_len;
                        addr_d       = req_addr;
                        value_d      = req_value;
                    end
                end
                BUSY_IC, BUSY_LS: begin
                    first_d = 1'b0;
                    if ((state_q == BUSY_IC) && flush) begin
                        cancel_d = 1'b1;
                    end
                    if (mc_ready) begin
                        // A first-cycle answer to a repeated request carries no
                        // fresh data; the earlier result is still in data_q.
                        if (!(first_q && same_q)) begin
                            data_d = mc_result;
                        end
                        last_ls_d = (state_q == BUSY_LS);
                        state_d   = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and latch registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            last_ls_q    <= 1'b0;
            owner_ls_q   <= 1'b0;
            cancel_q     <= 1'b0;
            first_q      <= 1'b0;
            same_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            data_q       <= 32'h0;
            wr_q         <= 1'b0;
            len_q        <= 3'b000;
            addr_q       <= 32'h0;
            value_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_ls_q    <= last_ls_d;
            owner_ls_q   <= owner_ls_d;
            cancel_q     <= cancel_d;
            first_q      <= first_d;
            same_q       <= same_d;
            prev_valid_q <= prev_valid_d;
            data_q       <= data_d;
            wr_q         <= wr_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            value_q      <= value_d;
        end
    end

    // A flush seen during the fetch or in its DONE cycle drops ic_done.
    assign ic_done    = (state_q == DONE) && !owner_ls_q && !cancel_q && !flush;
    assign ls_done    = (state_q == DONE) && owner_ls_q;
    assign ic_data    = data_q;
    assign ls_data    = data_q;
    assign mc_waiting = (state_q == BUSY_IC) || (state_q == BUSY_LS);
    assign mc_wr      = wr_q;
    assign mc_len     = len_q;
    assign mc_addr    = addr_q;
    assign mc_value   = value_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small memory-controller model:
// fixed latency, byte memory, and a first-cycle answer (with junk data)
// when a request repeats the previous one.
module tb_mem_arbiter;

    localparam int MDL_LAT = 3;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_done;
    logic [31:0] ic_data;
    logic        ls_req;
    logic        ls_wr;
    logic [2:0]  ls_len;
    logic [31:0] ls_addr;
    logic [31:0] ls_value;
    logic        ls_done;
    logic [31:0] ls_data;
    logic        io_buffer_full;
    logic        flush;
    logic        mc_waiting;
    logic        mc_wr;
    logic [2:0]  mc_len;
    logic [31:0] mc_addr;
    logic [31:0] mc_value;
    logic        mc_ready;
    logic [31:0] mc_result;

    int checks = 0;
    int failures = 0;
    bit both_seen = 1'b0;

    logic [7:0]  mem [0:4095];
    bit          mdl_busy;
    bit          mdl_have_prev;
    logic [67:0] mdl_prev;
    int          mdl_cnt;

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr),
        .ls_value(ls_value), .ls_done(ls_done), .ls_data(ls_data),
        .io_buffer_full(io_buffer_full), .flush(flush),
        .mc_waiting(mc_waiting), .mc_wr(mc_wr), .mc_len(mc_len), .mc_addr(mc_addr),
        .mc_value(mc_value), .mc_ready(mc_ready), .mc_result(mc_result)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic mdl_access(output logic [31:0] res);
        logic [31:0] v;
        logic [11:0] a;
        int n;
        n = 1 << mc_len[1:0];
        v = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                a = mc_addr[11:0] + 12'(i);
                if (mc_wr) mem[a] = mc_value[8*i +: 8];
                else v[8*i +: 8] = mem[a];
            end
        end
        if (!mc_wr && mc_len[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (!mc_wr && mc_len[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
        res = mc_wr ? 32'h0 : v;
    endtask

    // Controller model, acting on the falling edge.
    initial begin
        logic [31:0] r;
        mc_ready = 1'b0;
        mc_result = 32'h0;
        mdl_busy = 1'b0;
        mdl_have_prev = 1'b0;
        mdl_prev = '0;
        mdl_cnt = 0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                mc_ready = 1'b0;
                mc_result = 32'h0;
                mdl_busy = 1'b0;
                mdl_have_prev = 1'b0;
                for (int i = 0; i < 4096; i++) mem[i[11:0]] = 8'h00;
                mem[12'h100] = 8'h13; mem[12'h101] = 8'h05;
                mem[12'h104] = 8'h44; mem[12'h105] = 8'h33;
                mem[12'h106] = 8'h22; mem[12'h107] = 8'h11;
                mem[12'h200] = 8'h80;
            end else if (!mc_waiting) begin
                mc_ready = 1'b0;
                mdl_busy = 1'b0;
            end else if (!mdl_busy) begin
                mdl_busy = 1'b1;
                mdl_cnt = 0;
                if (mdl_have_prev && ({mc_wr, mc_len, mc_addr, mc_value} == mdl_prev)) begin
                    mc_ready = 1'b1;
                    mc_result = 32'hDEADBEEF;
                end
                mdl_prev = {mc_wr, mc_len, mc_addr, mc_value};
                mdl_have_prev = 1'b1;
            end else if (!mc_ready) begin
                mdl_cnt++;
                if (mdl_cnt >= MDL_LAT) begin
                    mdl_access(r);
                    mc_result = r;
                    mc_ready = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply_reset();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
    endtask

    // Advance until a done pulse or the budget runs out. rdy_b is mc_ready as
    // seen by the edge that produced the final sample.
    task automatic wait_done(input int budget, output bit got_ic, output bit got_ls,
                             output bit rdy_b, output int cycles, output bit len_odd);
        got_ic = 1'b0; got_ls = 1'b0; rdy_b = 1'b0; cycles = 0; len_odd = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            #1;
            rdy_b = mc_ready;
            @(posedge clk_in);
            #1;
            cycles++;
            if (ic_done && ls_done) both_seen = 1'b1;
            if (mc_waiting && mc_len != 3'b010) len_odd = 1'b1;
            if (ic_done || ls_done) begin
                got_ic = ic_done;
                got_ls = ls_done;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (ic_done !== 1'b0) begin failures++; $display("FAIL reset_ic_done actual=%0b required=0", ic_done); end
        checks++; if (ls_done !== 1'b0) begin failures++; $display("FAIL reset_ls_done actual=%0b required=0", ls_done); end
        checks++; if (mc_waiting !== 1'b0) begin failures++; $display("FAIL reset_mc_waiting actual=%0b required=0", mc_waiting); end
        checks++; if ({mc_wr, mc_len, mc_addr, mc_value} !== 68'h0) begin failures++; $display("FAIL reset_latches actual=%0b/%b/%h/%h required=0", mc_wr, mc_len, mc_addr, mc_value); end
        checks++; if (ic_data !== 32'h0 || ls_data !== 32'h0) begin failures++; $display("FAIL reset_data actual=%h/%h required=0", ic_data, ls_data); end
    endtask

    task automatic test_single_fetch();
        bit gi, gl, rb, lo;
        int cy;
        ic_req = 1'b1; ic_addr = 32'h100;
        step();
        checks++; if (mc_waiting !== 1'b1) begin failures++; $display("FAIL fetch_grant actual=%0b required=1", mc_waiting); end
        checks++; if (mc_addr !== 32'h100 || mc_len !== 3'b010 || mc_wr !== 1'b0) begin failures++; $display("FAIL fetch_req actual=%h/%b/%0b required=100/010/0", mc_addr, mc_len, mc_wr); end
        wait_done(30, gi, gl, rb, cy, lo);
        checks++; if (gi !== 1'b1 || gl !== 1'b0) begin failures++; $display("FAIL fetch_done actual=ic%0b/ls%0b required=ic1/ls0", gi, gl); end
        checks++; if (ic_data !== 32'h00000513) begin failures++; $display("FAIL fetch_data actual=%h required=00000513", ic_data); end
        checks++; if (rb !== 1'b1) begin failures++; $display("FAIL fetch_latency actual=ready_before_done=%0b required=1", rb); end
        checks++; if (lo !== 1'b0) begin failures++; $display("FAIL fetch_len_stable actual=changed required=010"); end
        ic_req = 1'b0;
        step();
        checks++; if (ic_done !== 1'b0 || mc_waiting !== 1'b0) begin failures++; $display("FAIL fetch_pulse_end actual=%0b/%0b required=0/0", ic_done, mc_waiting); end
    endtask

    task automatic test_tie();
        bit gi, gl, rb, lo;
        int cy;
        apply_reset();
        ic_req = 1'b1; ic_addr = 32'h100;
        ls_req = 1'b1; ls_wr = 1'b0; ls_len = 3'b010; ls_addr = 32'h104; ls_value = 32'h0;
        step();
        checks++; if (mc_waiting !== 1'b1 || mc_addr !== 32'h104) begin failures++; $display("FAIL tie1_grant actual=%0b/%h required=1/00000104", mc_waiting, mc_addr); end
        wait_done(30, gi, gl, rb, cy, lo);
        checks++; if (gl !== 1'b1 || gi !== 1'b0 || ls_data !== 32'h11223344) begin failures++; $display("FAIL tie1_done actual=ls%0b/ic%0b/%h required=ls1/ic0/11223344", gl, gi, ls_data); end
        ls_addr = 32'h108;
        step();
        checks++; if (mc_waiting !== 1'b0 || ls_done !== 1'b0) begin failures++; $display("FAIL tie_idle actual=%0b/%0b required=0/0", mc_waiting, ls_done); end
        step();
        checks++; if (mc_waiting !== 1'b1 || mc_addr !== 32'h100) begin failures++; $display("FAIL tie2_grant actual=%0b/%h required=1/00000100", mc_waiting, mc_addr); end
        wait_done(30, gi, gl, rb, cy, lo);
        checks++; if (gi !== 1'b1 || ic_data !== 32'h00000513) begin failures++; $display("FAIL tie2_done actual=%0b/%h required=1/00000513", gi, ic_data); end
        ic_req = 1'b0;
        step();
        step();
        checks++; if (mc_waiting !== 1'b1 || mc_addr !== 32'h108) begin failures++; $display("FAIL tie2_ls_grant actual=%0b/%h required=1/00000108", mc_waiting, mc_addr); end
        wait_done(30, gi, gl, rb, cy, lo);
        checks++; if (gl !== 1'b1 || ls_data !== 32'h0) begin failures++; $display("FAIL tie2_ls_done actual=%0b/%h required=1/00000000", gl, ls_data); end
        ls_req = 1'b0;
        step();
    endtask

    task automatic test_io_stall();
        bit gi, gl, rb, lo, stall_bad;
        int cy;
        apply_reset();
        ls_req = 1'b1; ls_wr = 1'b1; ls_len = 3'b000; ls_addr = 32'h30000; ls_value = 32'h41;
        io_buffer_full = 1'b1;
        ic_req = 1'b1; ic_addr = 32'h10C;
        step();
        checks++; if (mc_waiting !== 1'b1 || mc_addr !== 32'h10C || mc_wr !== 1'b0) begin failures++; $display("FAIL io_ic_grant actual=%0b/%h/%0b required=1/0000010c/0", mc_waiting, mc_addr, mc_wr); end
        wait_done(30, gi, gl, rb, cy, lo);
        checks++; if (gi !== 1'b1 || ic_data !== 32'h0) begin failures++; $display("FAIL io_ic_done actual=%0b/%h required=1/00000000", gi, ic_data); end
        ic_req = 1'b0;
        stall_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mc_waiting !== 1'b0) stall_bad = 1'b1;
        end
        checks++; if (stall_bad !== 1'b0) begin failures++; $display("FAIL io_ls_held actual=granted required=held"); end
        io_buffer_full = 1'b0;
        step();
        checks++; if (mc_waiting !== 1'b1 || mc_wr !== 1'b1 || mc_len !== 3'b000) begin failures++; $display("FAIL io_ls_grant actual=%0b/%0b/%b required=1/1/000", mc_waiting, mc_wr, mc_len); end
        checks++; if (mc_addr !== 32'h30000 || mc_value !== 32'h41) begin failures++; $display("FAIL io_ls_fields actual=%h/%h required=00030000/00000041", mc_addr, mc_value); end
        wait_done(30, gi, gl, rb, cy, lo);
        checks++; if (gl !== 1'b1) begin failures++; $display("FAIL io_ls_done actual=%0b required=1", gl); end
        checks++; if (mem[12'h000] !== 8'h41) begin failures++; $display("FAIL io_write_byte actual=%h required=41", mem[12'h000]); end
        ls_req = 1'b0; ls_wr = 1'b0;
        step();
    endtask

    task automatic test_flush();
        bit gi, gl, rb, lo, saw_ic;
        int cy;
        ic_req = 1'b1; ic_addr = 32'h100;
        ls_req = 1'b1; ls_wr = 1'b0; ls_len = 3'b010; ls_addr = 32'h104; ls_value = 32'h0;
        step();
        checks++; if (mc_waiting !== 1'b1 || mc_addr !== 32'h100) begin failures++; $display("FAIL flush_ic_grant actual=%0b/%h required=1/00000100", mc_waiting, mc_addr); end
        step();
        step();
        flush = 1'b1; ic_req = 1'b0;
        step();
        flush = 1'b0;
        checks++; if (mc_waiting !== 1'b1) begin failures++; $display("FAIL flush_waiting actual=%0b required=1", mc_waiting); end
        saw_ic = 1'b0;
        rb = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_in);
            #1;
            rb = mc_ready;
            step();
            if (ic_done) saw_ic = 1'b1;
            if (!mc_waiting) break;
        end
        checks++; if (rb !== 1'b1) begin failures++; $display("FAIL flush_runs_to_ready actual=ready=%0b required=1", rb); end
        step();
        if (ic_done) saw_ic = 1'b1;
        checks++; if (mc_waiting !== 1'b0) begin failures++; $display("FAIL flush_idle actual=%0b required=0", mc_waiting); end
        checks++; if (saw_ic !== 1'b0) begin failures++; $display("FAIL flush_no_ic_done actual=%0b required=0", saw_ic); end
        step();
        checks++; if (mc_waiting !== 1'b1 || mc_addr !== 32'h104) begin failures++; $display("FAIL flush_ls_next actual=%0b/%h required=1/00000104", mc_waiting, mc_addr); end
        wait_done(30, gi, gl, rb, cy, lo);
        checks++; if (gl !== 1'b1 || ls_data !== 32'h11223344) begin failures++; $display("FAIL flush_ls_done actual=%0b/%h required=1/11223344", gl, ls_data); end
        ls_req = 1'b0;
        step();
    endtask

    task automatic test_repeat_read();
        bit gi, gl, rb, lo;
        int cy;
        ls_req = 1'b1; ls_wr = 1'b0; ls_len = 3'b100; ls_addr = 32'h200; ls_value = 32'h0;
        step();
        wait_done(30, gi, gl, rb, cy, lo);
        checks++; if (gl !== 1'b1 || ls_data !== 32'hFFFFFF80) begin failures++; $display("FAIL lb1_data actual=%0b/%h required=1/ffffff80", gl, ls_data); end
        step();
        step();
        checks++; if (mc_waiting !== 1'b1) begin failures++; $display("FAIL lb2_grant actual=%0b required=1", mc_waiting); end
        wait_done(30, gi, gl, rb, cy, lo);
        checks++; if (gl !== 1'b1 || ls_data !== 32'hFFFFFF80) begin failures++; $display("FAIL lb2_data actual=%0b/%h required=1/ffffff80", gl, ls_data); end
        checks++; if (cy !== 1) begin failures++; $display("FAIL lb2_hit_cycles actual=%0d required=1", cy); end
        ls_req = 1'b0;
        step();
    endtask

    task automatic test_reset_busy_ls();
        bit done_bad;
        ls_req = 1'b1; ls_wr = 1'b0; ls_len = 3'b010; ls_addr = 32'h300; ls_value = 32'h0;
        step();
        checks++; if (mc_waiting !== 1'b1 || mc_addr !== 32'h300) begin failures++; $display("FAIL rstls_grant actual=%0b/%h required=1/00000300", mc_waiting, mc_addr); end
        step();
        rst_in = 1'b1;
        step();
        checks++; if (mc_waiting !== 1'b0 || ls_done !== 1'b0 || ic_done !== 1'b0) begin failures++; $display("FAIL rstls_ctrl actual=%0b/%0b/%0b required=0/0/0", mc_waiting, ls_done, ic_done); end
        checks++; if ({mc_wr, mc_len, mc_addr, mc_value} !== 68'h0 || ls_data !== 32'h0) begin failures++; $display("FAIL rstls_zero actual=%h/%h/%h required=0", mc_addr, mc_value, ls_data); end
        rst_in = 1'b0;
        ls_req = 1'b0;
        done_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ls_done !== 1'b0 || mc_waiting !== 1'b0) done_bad = 1'b1;
        end
        checks++; if (done_bad !== 1'b0) begin failures++; $display("FAIL rstls_no_done actual=activity required=none"); end
    endtask

    task automatic test_freeze();
        bit gi, gl, rb, lo, hold_bad;
        int cy;
        ic_req = 1'b1; ic_addr = 32'h100; flush = 1'b1;
        step();
        checks++; if (mc_waiting !== 1'b0) begin failures++; $display("FAIL flush_blocks_ic actual=%0b required=0", mc_waiting); end
        flush = 1'b0; rdy_in = 1'b0;
        step();
        checks++; if (mc_waiting !== 1'b0) begin failures++; $display("FAIL rdy_blocks_grant actual=%0b required=0", mc_waiting); end
        rdy_in = 1'b1;
        step();
        checks++; if (mc_waiting !== 1'b1) begin failures++; $display("FAIL rdy_grant actual=%0b required=1", mc_waiting); end
        wait_done(30, gi, gl, rb, cy, lo);
        checks++; if (gi !== 1'b1 || ic_data !== 32'h00000513) begin failures++; $display("FAIL freeze_fetch actual=%0b/%h required=1/00000513", gi, ic_data); end
        rdy_in = 1'b0;
        hold_bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ic_done !== 1'b1) hold_bad = 1'b1;
        end
        checks++; if (hold_bad !== 1'b0) begin failures++; $display("FAIL freeze_done_held actual=dropped required=held"); end
        flush = 1'b1;
        #1;
        checks++; if (ic_done !== 1'b0) begin failures++; $display("FAIL done_flush_suppress actual=%0b required=0", ic_done); end
        flush = 1'b0;
        #1;
        rdy_in = 1'b1; ic_req = 1'b0;
        step();
        checks++; if (ic_done !== 1'b0 || mc_waiting !== 1'b0) begin failures++; $display("FAIL freeze_release actual=%0b/%0b required=0/0", ic_done, mc_waiting); end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        ic_req = 1'b0; ic_addr = 32'h0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_len = 3'b000; ls_addr = 32'h0; ls_value = 32'h0;
        io_buffer_full = 1'b0; flush = 1'b0;
        test_reset();
        test_single_fetch();
        test_tie();
        test_io_stall();
        test_flush();
        test_repeat_read();
        test_reset_busy_ls();
        test_freeze();
        checks++; if (both_seen !== 1'b0) begin failures++; $display("FAIL exclusive_done actual=both required=one"); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
